intr_sequencer: RTL and testbench
=================================

# intr_sequencer

Control sequencer for the front end of the 8-bit pipeline. It freezes the fetch stage and walks it through two flows:
- Boot: load PC from M[0].
- Interrupt: drain the pipeline, push return PC and flags onto the stack, load PC from M[1].

It drives the fetch stage's `intr_active` and redirect inputs, and is one requester on the shared data-memory port.

## Interface

Parameters
- `RESET_VEC`, 8'h00 — memory address holding the boot PC
- `INTR_VEC`, 8'h01 — memory address holding the ISR PC

Ports
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `intr_req`  in  1  external interrupt request; a one-cycle pulse or a level
- `resume_pc`  in  8  address of the oldest unissued instruction (decode-stage PC)
- `flags`  in  4  current CCR
- `sp`  in  8  current stack pointer
- `pipe_empty`  in  1  no valid instruction in execute, memory or writeback
- `branch_taken`  in  1  branch resolved taken this cycle
- `branch_target`  in  8  target of that branch
- `rti_done`  in  1  RTI retired (PC and flags already restored)
- `mem_gnt`  in  1  memory port granted this cycle
- `mem_rdata`  in  8  read data, valid in the `mem_gnt` cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write enable
- `mem_addr`  out  8  memory address
- `mem_wdata`  out  8  write data
- `sp_dec`  out  1  one-cycle pulse: decrement SP by 1
- `intr_active`  out  1  freeze fetch and flush IF/ID
- `redirect`  out  1  one-cycle pulse: load PC
- `redirect_target`  out  8  PC value to load
- `intr_ack`  out  1  one-cycle pulse at interrupt acceptance
- `in_isr`  out  1  ISR in progress

## Operation

States: BOOT, IDLE, DRAIN, PUSH_PC, PUSH_FLG, VEC, REDIR, ISR.

- **Reset**
  - State goes to BOOT.
  - `pending`, `in_isr`, `mem_req`, `redirect`, `sp_dec` and `intr_ack` are cleared.
  - `intr_active` is 1; `mem_addr`, `mem_wdata` and `redirect_target` are 0.
  - Reset has priority over everything and aborts any flow, including mid-push.
- **Pending latch**
  - Set on any cycle with `intr_req`=1.
  - Cleared only at acceptance.
  - Requests arriving while already pending merge into the one pending interrupt.
- **BOOT**
  - Read `RESET_VEC`.
  - On `mem_gnt`, latch `mem_rdata` into `tgt` and go to REDIR.
- **IDLE**
  - `intr_active`=0.
  - If `pending` and not `in_isr`:
    - Pulse `intr_ack`.
    - Capture `ret_pc` ← `resume_pc`, `flg` ← `flags`, `sp_base` ← `sp`.
    - Go to DRAIN.
- **DRAIN**
  - `intr_active`=1.
  - If `branch_taken`, `ret_pc` ← `branch_target` (the last one wins). Fetch ignores branches while frozen, so the controller owns the redirect.
  - Go to PUSH_PC on the first cycle with `pipe_empty`=1 and `branch_taken`=0.
- **PUSH_PC**
  - Write `ret_pc` to `sp_base`.
  - On `mem_gnt`, pulse `sp_dec` and go to PUSH_FLG.
- **PUSH_FLG**
  - Write {4'b0, `flg`} to `sp_base`−1 (8-bit wrap: `sp_base`=0 gives address 255).
  - On `mem_gnt`, pulse `sp_dec` and go to VEC.
- **VEC**
  - Read `INTR_VEC`.
  - On `mem_gnt`, `tgt` ← `mem_rdata`; go to REDIR.
- **REDIR**
  - Pulse `redirect` with `redirect_target`=`tgt`; `intr_active` stays 1 this cycle.
  - Go to IDLE if coming from BOOT; otherwise set `in_isr` and go to ISR.
- **ISR**
  - `intr_active`=0.
  - New requests only set `pending`.
  - On `rti_done`, clear `in_isr` and go to IDLE. A still-pending interrupt is accepted on the next cycle.
- `rti_done` outside ISR is ignored.

## Timing

- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - They are held stable from the first cycle of the state until the `mem_gnt` cycle inclusive; `mem_req` drops the cycle after.
  - Each memory state takes at least 1 cycle, plus 1 per cycle without `mem_gnt`.
- `intr_active` is 1 in BOOT, DRAIN, PUSH_PC, PUSH_FLG, VEC and REDIR, and 0 otherwise.
- Latency: interrupt request to `intr_ack` is 1 cycle when idle and not in an ISR.
- With pipe already empty and grant always high, the sequence is:
  - `intr_ack`, then DRAIN (1 cycle), PUSH_PC (1), PUSH_FLG (1), VEC (1), REDIR (1).
  - `redirect` fires 5 cycles after `intr_ack`.
  - The first ISR instruction is fetched on the cycle after `redirect`.
- Boot with grant always high: `redirect` fires in the 2nd cycle after reset deasserts.
- A `branch_taken` in the same cycle as `pipe_empty` keeps the controller in DRAIN one more cycle.

## Structure

- Shared package `risc_pkg`:
  - state enum `intr_state_t`
  - `RESET_VEC` / `INTR_VEC` defaults
  - `ADDR_W`=8, `FLAG_W`=4
- Single module with no sub-module. The memory-request registers sit inline in the FSM.

## Test plan

- **Boot:** reset, M[0]=8'h20, gnt held low for 2 cycles → `redirect`=1 with `redirect_target`=8'h20 exactly once; `intr_active` then drops to 0.
- **Basic interrupt:**
  - Setup: `resume_pc`=8'h35, `flags`=4'hA, `sp`=8'hFF, M[1]=8'h80, pipe empty, gnt=1.
  - Required: writes M[FF]=8'h35, then M[FE]=8'h0A; 2 `sp_dec` pulses; `redirect` to 8'h80 five cycles after `intr_ack`.
- **Branch during drain:** `pipe_empty`=0 for 3 cycles, with `branch_taken` and target 8'h44 on cycle 2 → pushed PC is 8'h44.
- **Nested request:** `intr_req` during ISR → no `intr_ack` until `rti_done`; second acceptance occurs exactly 1 cycle after `rti_done`.
- **SP wrap:** `sp`=8'h00 → writes to addresses 8'h00 then 8'hFF.
- **Reset mid-flow:** assert reset in PUSH_FLG → next cycle state is BOOT, `mem_req`=0, `in_isr`=0, `pending` cleared.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit pipeline front end.
// Holds the interrupt sequencer state encoding and vector defaults.
package risc_pkg;

  localparam int ADDR_W = 8;
  localparam int FLAG_W = 4;

  localparam logic [ADDR_W-1:0] RESET_VEC_DEF = 8'h00;
  localparam logic [ADDR_W-1:0] INTR_VEC_DEF  = 8'h01;

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_PUSH_PC  = 3'd3,
    ST_PUSH_FLG = 3'd4,
    ST_VEC      = 3'd5,
    ST_REDIR    = 3'd6,
    ST_ISR      = 3'd7
  } intr_state_t;

endpackage

// File: rtl/intr_sequencer.sv
// Boot / interrupt sequencer: freezes fetch, drains, pushes PC+flags,
// then redirects fetch to the vector loaded from memory.
module intr_sequencer
  import risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [ADDR_W-1:0] INTR_VEC  = INTR_VEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intr_req,
  input  logic [ADDR_W-1:0] resume_pc,
  input  logic [FLAG_W-1:0] flags,
  input  logic [ADDR_W-1:0] sp,
  input  logic              pipe_empty,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              rti_done,
  input  logic              mem_gnt,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              sp_dec,
  output logic              intr_active,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              intr_ack,
  output logic              in_isr
);

  intr_state_t       state_q, state_d;
  logic              pending_q, pending_d;
  logic              in_isr_q, in_isr_d;
  logic              boot_q, boot_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic [FLAG_W-1:0] flg_q, flg_d;
  logic [ADDR_W-1:0] sp_base_q, sp_base_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;

  logic gnt;
  logic ack;

  // a grant only counts while our registered request is up
  assign gnt = mem_req_q & mem_gnt;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | intr_req;
    in_isr_d  = in_isr_q;
    boot_d    = boot_q;
    ret_pc_d  = ret_pc_q;
    flg_d     = flg_q;
    sp_base_d = sp_base_q;
    tgt_d     = tgt_q;
    ack       = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        boot_d = 1'b1;
        if (gnt) begin
          tgt_d   = mem_rdata;
          state_d = ST_REDIR;
        end
      end
      ST_IDLE: begin
        if (pending_q && !in_isr_q) begin
          ack       = 1'b1;
          boot_d    = 1'b0;
          ret_pc_d  = resume_pc;
          flg_d     = flags;
          sp_base_d = sp;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // fetch ignores branches while frozen, so track the return PC here
        if (branch_taken) begin
          ret_pc_d = branch_target;
        end else if (pipe_empty) begin
          state_d = ST_PUSH_PC;
        end
      end
      ST_PUSH_PC: begin
        if (gnt) state_d = ST_PUSH_FLG;
      end
      ST_PUSH_FLG: begin
        if (gnt) state_d = ST_VEC;
      end
      ST_VEC: begin
        if (gnt) begin
          tgt_d   = mem_rdata;
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        in_isr_d = !boot_q;
        state_d  = boot_q ? ST_IDLE : ST_ISR;
      end
      ST_ISR: begin
        if (rti_done) begin
          in_isr_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (ack) pending_d = intr_req;
  end

  // request registers are loaded for the state being entered
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_d)
      ST_BOOT: begin
        mem_req_d  = 1'b1;
        mem_addr_d = RESET_VEC;
      end
      ST_PUSH_PC: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_base_d;
        mem_wdata_d = ret_pc_d;
      end
      ST_PUSH_FLG: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_base_d - {{(ADDR_W-1){1'b0}}, 1'b1};
        mem_wdata_d = {{(ADDR_W-FLAG_W){1'b0}}, flg_d};
      end
      ST_VEC: begin
        mem_req_d  = 1'b1;
        mem_addr_d = INTR_VEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pending_q   <= 1'b0;
      in_isr_q    <= 1'b0;
      boot_q      <= 1'b1;
      ret_pc_q    <= '0;
      flg_q       <= '0;
      sp_base_q   <= '0;
      tgt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      in_isr_q    <= in_isr_d;
      boot_q      <= boot_d;
      ret_pc_q    <= ret_pc_d;
      flg_q       <= flg_d;
      sp_base_q   <= sp_base_d;
      tgt_q       <= tgt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign sp_dec          = gnt & mem_we_q & !reset;
  assign intr_ack        = ack & !reset;
  assign redirect        = (state_q == ST_REDIR) & !reset;
  assign redirect_target = tgt_q;
  assign in_isr          = in_isr_q;
  assign intr_active     = !((state_q == ST_IDLE) ||
                             (state_q == ST_ISR));

endmodule

// File: tb/tb_intr_sequencer.sv
// Self-checking bench for intr_sequencer: vector table of interrupt
// flows plus hand-written boot, drain, nesting and reset sequences.
module tb_intr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       intr_req;
  logic [7:0] resume_pc;
  logic [3:0] flags;
  logic [7:0] sp;
  logic       pipe_empty;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       rti_done;
  logic       mem_gnt;
  logic [7:0] mem_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       sp_dec;
  logic       intr_active;
  logic       redirect;
  logic [7:0] redirect_target;
  logic       intr_ack;
  logic       in_isr;

  intr_sequencer dut (
    .clk(clk),
    .reset(reset),
    .intr_req(intr_req),
    .resume_pc(resume_pc),
    .flags(flags),
    .sp(sp),
    .pipe_empty(pipe_empty),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .rti_done(rti_done),
    .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .sp_dec(sp_dec),
    .intr_active(intr_active),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .intr_ack(intr_ack),
    .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       gnt_en;

  assign mem_gnt   = mem_req & gnt_en;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] pc;
    logic [3:0] fl;
    logic [7:0] sp;
    logic [7:0] vec;
    logic [7:0] a0;
    logic [7:0] d0;
    logic [7:0] a1;
    logic [7:0] d1;
    logic [7:0] tgt;
  } vec_t;

  wr_t        exp_wr [$];
  logic [7:0] exp_tgt [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_redir = 0;
  int n_ack = 0;
  int n_sp = 0;
  int ack_cyc = 0;
  int redir_cyc = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  function automatic void push_wr(input logic [7:0] a,
                                  input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard monitor: writes and redirects are popped as they occur
  initial forever begin
    wr_t w;
    logic [7:0] t;
    @(negedge clk);
    if (!reset) begin
      if (mem_req && mem_gnt && mem_we) begin
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: got %h<=%h, want none",
                   mem_addr, mem_wdata);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.a));
          chk("wr_data", 32'(mem_wdata), 32'(w.d));
        end
      end
      if (redirect) begin
        n_redir++;
        redir_cyc = cyc;
        if (exp_tgt.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL redir_unexpected: got %h, want none",
                   redirect_target);
        end else begin
          t = exp_tgt.pop_front();
          chk("redir_tgt", 32'(redirect_target), 32'(t));
        end
      end
      if (intr_ack) begin
        n_ack++;
        ack_cyc = cyc;
      end
      if (sp_dec) n_sp++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic wait_redir(input int r0, input string nm);
    for (int i = 0; i < 40; i++) begin
      if (n_redir != r0) break;
      next();
      settle();
    end
    chk(nm, 32'(n_redir - r0), 32'd1);
  endtask

  task automatic do_rti();
    next();
    rti_done = 1'b1;
    next();
    rti_done = 1'b0;
    settle();
    chk("isr_exit", 32'(in_isr), 32'd0);
    chk("idle_active", 32'(intr_active), 32'd0);
  endtask

  task automatic run_flow(input vec_t v, input string nm);
    int s0;
    int r0;
    resume_pc  = v.pc;
    flags      = v.fl;
    sp         = v.sp;
    mem[1]     = v.vec;
    pipe_empty = 1'b1;
    gnt_en     = 1'b1;
    push_wr(v.a0, v.d0);
    push_wr(v.a1, v.d1);
    exp_tgt.push_back(v.tgt);
    s0 = n_sp;
    r0 = n_redir;
    next();
    intr_req = 1'b1;
    next();
    intr_req = 1'b0;
    wait_redir(r0, {nm, "_redir"});
    chk({nm, "_lat"}, 32'(redir_cyc - ack_cyc), 32'd5);
    chk({nm, "_spdec"}, 32'(n_sp - s0), 32'd2);
    next();
    settle();
    chk({nm, "_in_isr"}, 32'(in_isr), 32'd1);
    chk({nm, "_isr_act"}, 32'(intr_active), 32'd0);
  endtask

  vec_t tbl [4];

  initial begin
    int a0;
    int r0;
    int c0;
    int rti_cyc;

    tbl[0] = '{8'h35, 4'hA, 8'hFF, 8'h80,
               8'hFF, 8'h35, 8'hFE, 8'h0A, 8'h80};
    tbl[1] = '{8'h12, 4'h5, 8'h00, 8'h90,
               8'h00, 8'h12, 8'hFF, 8'h05, 8'h90};
    tbl[2] = '{8'hC7, 4'hF, 8'h01, 8'h3C,
               8'h01, 8'hC7, 8'h00, 8'h0F, 8'h3C};
    tbl[3] = '{8'h00, 4'h0, 8'h80, 8'hFF,
               8'h80, 8'h00, 8'h7F, 8'h00, 8'hFF};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h20;
    mem[1] = 8'h80;

    reset         = 1'b1;
    intr_req      = 1'b0;
    resume_pc     = 8'h00;
    flags         = 4'h0;
    sp            = 8'hFF;
    pipe_empty    = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    rti_done      = 1'b0;
    gnt_en        = 1'b0;

    next();
    next();
    next();
    settle();
    chk("rst_active", 32'(intr_active), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_redir", 32'(redirect), 32'd0);
    chk("rst_tgt", 32'(redirect_target), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_isr", 32'(in_isr), 32'd0);
    chk("rst_ack", 32'(intr_ack), 32'd0);
    chk("rst_spdec", 32'(sp_dec), 32'd0);

    // boot with grant held low for two request cycles
    exp_tgt.push_back(8'h20);
    r0 = n_redir;
    next();
    reset = 1'b0;
    next();
    settle();
    chk("boot_req", 32'(mem_req), 32'd1);
    chk("boot_addr", 32'(mem_addr), 32'd0);
    chk("boot_we", 32'(mem_we), 32'd0);
    next();
    next();
    gnt_en = 1'b1;
    wait_redir(r0, "boot_redir");
    next();
    settle();
    chk("boot_idle_act", 32'(intr_active), 32'd0);
    chk("boot_redir_drop", 32'(redirect), 32'd0);
    next();
    next();
    settle();
    chk("boot_once", 32'(n_redir - r0), 32'd1);

    foreach (tbl[i]) begin
      run_flow(tbl[i], $sformatf("tbl%0d", i));
      do_rti();
    end

    // branch resolved during drain, then one with pipe_empty
    resume_pc  = 8'h50;
    flags      = 4'h3;
    sp         = 8'hF0;
    mem[1]     = 8'h88;
    pipe_empty = 1'b0;
    push_wr(8'hF0, 8'h44);
    push_wr(8'hEF, 8'h03);
    exp_tgt.push_back(8'h88);
    r0 = n_redir;
    next();
    intr_req = 1'b1;
    next();
    intr_req = 1'b0;
    next();
    next();
    branch_taken  = 1'b1;
    branch_target = 8'h44;
    next();
    branch_taken = 1'b0;
    settle();
    chk("drain_hold", 32'(mem_req), 32'd0);
    chk("drain_act", 32'(intr_active), 32'd1);
    next();
    pipe_empty   = 1'b1;
    branch_taken = 1'b1;
    next();
    branch_taken = 1'b0;
    settle();
    chk("drain_extra", 32'(mem_req), 32'd0);
    next();
    settle();
    chk("push_pc_req", 32'(mem_req), 32'd1);
    chk("push_pc_addr", 32'(mem_addr), 32'hF0);
    chk("push_pc_data", 32'(mem_wdata), 32'h44);
    wait_redir(r0, "br_redir");
    do_rti();

    // request during ISR is held until rti_done
    run_flow('{8'h60, 4'h1, 8'h40, 8'hA0,
               8'h40, 8'h60, 8'h3F, 8'h01, 8'hA0}, "nest");
    resume_pc = 8'h61;
    flags     = 4'h6;
    sp        = 8'h3E;
    mem[1]    = 8'hA4;
    push_wr(8'h3E, 8'h61);
    push_wr(8'h3D, 8'h06);
    exp_tgt.push_back(8'hA4);
    a0 = n_ack;
    next();
    intr_req = 1'b1;
    next();
    intr_req = 1'b0;
    for (int i = 0; i < 4; i++) next();
    settle();
    chk("nest_no_ack", 32'(n_ack - a0), 32'd0);
    chk("nest_isr", 32'(in_isr), 32'd1);
    r0 = n_redir;
    next();
    rti_done = 1'b1;
    rti_cyc  = cyc;
    next();
    rti_done = 1'b0;
    settle();
    chk("nest_ack", 32'(intr_ack), 32'd1);
    chk("nest_ack_lat", 32'(ack_cyc - rti_cyc), 32'd1);
    wait_redir(r0, "nest_redir");
    do_rti();

    // reset while PUSH_FLG waits; a request raised mid-flow is dropped
    resume_pc = 8'h70;
    flags     = 4'h2;
    sp        = 8'h20;
    mem[1]    = 8'hB0;
    push_wr(8'h20, 8'h70);
    next();
    intr_req = 1'b1;
    next();
    intr_req = 1'b0;
    next();
    next();
    intr_req = 1'b1;
    next();
    intr_req = 1'b0;
    gnt_en   = 1'b0;
    settle();
    chk("mid_flg_addr", 32'(mem_addr), 32'h1F);
    chk("mid_flg_data", 32'(mem_wdata), 32'h02);
    next();
    reset = 1'b1;
    next();
    settle();
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_isr", 32'(in_isr), 32'd0);
    chk("mid_rst_act", 32'(intr_active), 32'd1);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    exp_tgt.push_back(8'h20);
    r0 = n_redir;
    a0 = n_ack;
    gnt_en = 1'b1;
    next();
    reset = 1'b0;
    c0    = cyc;
    wait_redir(r0, "reboot_redir");
    chk("reboot_lat", 32'(redir_cyc - c0), 32'd2);
    for (int i = 0; i < 5; i++) next();
    settle();
    chk("pending_cleared", 32'(n_ack - a0), 32'd0);
    chk("reboot_idle", 32'(intr_active), 32'd0);

    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("tgt_queue_empty", 32'(exp_tgt.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
